// File: rtl/dmem_resp_if.sv
// Request/response bundle between the pipeline memory stage (master) and dmem_resp (slave).
interface dmem_resp_if;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        readWr;
    logic        writeWr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wdone;
    logic        busy;
    logic        err;

    modport master (output memAddr, memData, readWr, writeWr, rmask, wmask,
                    input  rdata, rvalid, wdone, busy, err);
    modport slave  (input  memAddr, memData, readWr, writeWr, rmask, wmask,
                    output rdata, rvalid, wdone, busy, err);
endinterface

// File: rtl/dmem_resp.sv
// Word-organised data memory with byte-lane masks, legality checks and a response FSM.
// Build option: define DMEM_WAIT_EN to insert WAIT_CYCLES wait states per access.
module dmem_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    dmem_resp_if.slave bus
);

`ifdef DMEM_WAIT_EN
    localparam int WAIT_N = WAIT_CYCLES;
`else
    localparam int WAIT_N = 0 * WAIT_CYCLES;  // wait states compiled out
`endif
    localparam bit WAIT_PATH = (WAIT_N > 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [31:0]           mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] cmd_idx;
    logic [31:0]           cmd_data;
    logic [3:0]            cmd_rmask;
    logic [3:0]            cmd_wmask;
    logic                  cmd_wr;
    logic                  cmd_oor;
    logic                  cmd_both;
    logic [31:0]           rdata_q;

    logic                  req;
    logic                  accept;
    logic                  in_resp;
    logic                  access_ok;
    logic                  wr_en;
    logic [31:0]           rd_word;
    logic                  unused_addr_lsbs;

    function automatic logic legal_mask(input logic [3:0] m);
        case (m)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    assign req              = bus.readWr | bus.writeWr;
    assign unused_addr_lsbs = ^bus.memAddr[1:0];

`ifdef DMEM_WAIT_EN
    localparam int            CW       = (WAIT_N > 1) ? $clog2(WAIT_N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_N > 0) ? WAIT_N - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || state != WAIT || cnt == CNT_LAST) cnt <= '0;
        else                                         cnt <= cnt + CW'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = WAIT_PATH ? WAIT : RESP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
`ifdef DMEM_WAIT_EN
                if (cnt == CNT_LAST) state_nxt = RESP;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command is captured once at acceptance; WAIT never looks at the bus again.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            cmd_idx   <= bus.memAddr[ADDR_WIDTH+1:2];
            cmd_oor   <= (bus.memAddr >> (ADDR_WIDTH + 2)) != '0;
            cmd_data  <= bus.memData;
            cmd_rmask <= bus.rmask;
            cmd_wmask <= bus.wmask;
            cmd_wr    <= bus.writeWr;
            cmd_both  <= bus.readWr & bus.writeWr;
        end
    end

    assign in_resp   = (state == RESP) && !rst;
    assign access_ok = legal_mask(cmd_wr ? cmd_wmask : cmd_rmask) && !cmd_oor;
    assign wr_en     = in_resp && cmd_wr && access_ok;
    assign rd_word   = access_ok ? (mem[cmd_idx] & lanes(cmd_rmask)) : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cmd_wmask[i]) mem[cmd_idx][8*i +: 8] <= cmd_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                     rdata_q <= '0;
        else if (in_resp && !cmd_wr) rdata_q <= rd_word;
    end

    // Read data is live during the RESP cycle so a write in the previous RESP is visible.
    always_comb begin
        bus.rvalid = in_resp && !cmd_wr;
        bus.wdone  = in_resp && cmd_wr;
        bus.err    = in_resp && (!access_ok || cmd_both);
        bus.rdata  = rst ? '0 : ((in_resp && !cmd_wr) ? rd_word : rdata_q);
`ifdef DMEM_WAIT_EN
        bus.busy   = !rst && ((state == WAIT) || (req && WAIT_PATH));
`else
        bus.busy   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: a reference memory model predicts every response.
module tb_dmem_resp;
    localparam int AW = 10;
    localparam int WC = 2;
`ifdef DMEM_WAIT_EN
    localparam int EXP_LAT = WC + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rm;
        logic [3:0]  wm;
    } req_t;

    typedef struct {
        logic        rv;
        logic        wd;
        logic        er;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    dmem_resp_if bus ();

    dmem_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic req_t wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        return '{rd: 1'b0, wr: 1'b1, addr: a, data: d, rm: 4'h0, wm: m};
    endfunction

    function automatic req_t rd_req(input logic [31:0] a, input logic [3:0] m);
        return '{rd: 1'b1, wr: 1'b0, addr: a, data: 32'h0, rm: m, wm: 4'h0};
    endfunction

    function automatic req_t rw_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        return '{rd: 1'b1, wr: 1'b1, addr: a, data: d, rm: 4'hF, wm: m};
    endfunction

    function automatic bit legal(input logic [3:0] m);
        return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // Reference model: updates the shadow memory and returns the response the DUT owes.
    function automatic exp_t predict(input req_t r);
        exp_t        e;
        bit          oor;
        int          idx;
        logic [31:0] w;
        oor = (r.addr >> (AW + 2)) != 0;
        idx = int'(r.addr[AW+1:2]);
        w   = model.exists(idx) ? model[idx] : 32'h0;
        e   = '{rv: 1'b0, wd: 1'b0, er: 1'b0, rd: 32'h0};
        if (r.wr) begin
            e.wd = 1'b1;
            e.er = oor || !legal(r.wm) || r.rd;
            if (!oor && legal(r.wm)) begin
                for (int b = 0; b < 4; b++)
                    if (r.wm[b]) w[8*b +: 8] = r.data[8*b +: 8];
                model[idx] = w;
            end
        end else if (r.rd) begin
            e.rv = 1'b1;
            e.er = oor || !legal(r.rm);
            if (!e.er)
                e.rd = w & {{8{r.rm[3]}}, {8{r.rm[2]}}, {8{r.rm[1]}}, {8{r.rm[0]}}};
        end
        return e;
    endfunction

    task automatic drive(input req_t r);
        bus.readWr  = r.rd;
        bus.writeWr = r.wr;
        bus.memAddr = r.addr;
        bus.memData = r.data;
        bus.rmask   = r.rm;
        bus.wmask   = r.wm;
    endtask

    task automatic drive_idle();
        bus.readWr  = 1'b0;
        bus.writeWr = 1'b0;
    endtask

    // Issue one single-cycle request and capture the first response pulse (lat=0 if no pulse arrives).
    task automatic run_one(input req_t r, output int lat, output exp_t got);
        sb.push_back(predict(r));
        drive(r);
        @(posedge clk);
        #1;
        drive_idle();
        lat = 0;
        got = '{rv: 1'b0, wd: 1'b0, er: 1'b0, rd: 32'h0};
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.rvalid || bus.wdone) begin
                lat = i;
                got = '{rv: bus.rvalid, wd: bus.wdone, er: bus.err, rd: bus.rdata};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(wr_req(32'h10, 32'h0BAD0BAD, 4'hF));
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.rvalid, bus.wdone, bus.err, bus.rdata} !== 36'h0) begin
            failures++;
            $display("FAIL reset_hold: got busy=%0b rv=%0b wd=%0b err=%0b rdata=%08h, expected all zero",
                     bus.busy, bus.rvalid, bus.wdone, bus.err, bus.rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.rvalid, bus.wdone, bus.err, bus.rdata} !== 36'h0) begin
            failures++;
            $display("FAIL reset_release: got busy=%0b rv=%0b wd=%0b err=%0b rdata=%08h, expected all zero",
                     bus.busy, bus.rvalid, bus.wdone, bus.err, bus.rdata);
        end
    endtask

    task automatic test_word_rw();
        req_t        tbl[$];
        logic [31:0] seen[$];
        exp_t        e, g;
        int          lat;
        tbl.push_back(wr_req(32'h10, 32'hDEADBEEF, 4'hF));
        tbl.push_back(rd_req(32'h10, 4'hF));
        tbl.push_back(rd_req(32'h10, 4'h3));
        tbl.push_back(rd_req(32'h13, 4'hC));
        foreach (tbl[i]) begin
            run_one(tbl[i], lat, g);
            seen.push_back(g.rd);
            e = sb.pop_front();
            checks++;
            if (lat != EXP_LAT || g.rv !== e.rv || g.wd !== e.wd || g.er !== e.er || (e.rv && g.rd !== e.rd)) begin
                failures++;
                $display("FAIL word_rw[%0d]: got rv=%0b wd=%0b err=%0b rdata=%08h lat=%0d, expected rv=%0b wd=%0b err=%0b rdata=%08h lat=%0d",
                         i, g.rv, g.wd, g.er, g.rd, lat, e.rv, e.wd, e.er, e.rd, EXP_LAT);
            end
        end
        checks++;
        if (seen[1] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_rw_value: got %08h expected deadbeef", seen[1]);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.rdata !== 32'hDEAD0000 || bus.rvalid || bus.wdone || bus.err) begin
                failures++;
                $display("FAIL rdata_hold: got rdata=%08h rv=%0b wd=%0b err=%0b, expected rdata=dead0000 and no pulses",
                         bus.rdata, bus.rvalid, bus.wdone, bus.err);
            end
        end
    endtask

    task automatic test_byte_lanes();
        req_t        tbl[$];
        logic [31:0] seen[$];
        exp_t        e, g;
        int          lat;
        tbl.push_back(wr_req(32'h20, 32'h11223344, 4'hF));
        tbl.push_back(wr_req(32'h20, 32'h000000AA, 4'h1));
        tbl.push_back(rd_req(32'h20, 4'hF));
        tbl.push_back(rd_req(32'h20, 4'hC));
        tbl.push_back(wr_req(32'h23, 32'hAB000000, 4'h8));
        tbl.push_back(rd_req(32'h20, 4'h2));
        tbl.push_back(rd_req(32'h20, 4'hF));
        foreach (tbl[i]) begin
            run_one(tbl[i], lat, g);
            seen.push_back(g.rd);
            e = sb.pop_front();
            checks++;
            if (lat != EXP_LAT || g.rv !== e.rv || g.wd !== e.wd || g.er !== e.er || (e.rv && g.rd !== e.rd)) begin
                failures++;
                $display("FAIL byte_lanes[%0d]: got rv=%0b wd=%0b err=%0b rdata=%08h lat=%0d, expected rv=%0b wd=%0b err=%0b rdata=%08h lat=%0d",
                         i, g.rv, g.wd, g.er, g.rd, lat, e.rv, e.wd, e.er, e.rd, EXP_LAT);
            end
        end
        checks++;
        if (seen[2] !== 32'h112233AA || seen[3] !== 32'h11220000) begin
            failures++;
            $display("FAIL byte_lanes_value: got %08h/%08h expected 112233aa/11220000", seen[2], seen[3]);
        end
    endtask

    task automatic test_illegal();
        req_t        tbl[$];
        logic [31:0] seen[$];
        exp_t        e, g;
        int          lat;
        tbl.push_back(wr_req(32'h00, 32'h0BADF00D, 4'hF));
        tbl.push_back(wr_req(32'h30, 32'h55667788, 4'hF));
        tbl.push_back(wr_req(32'h30, 32'hFFFFFFFF, 4'b0101));
        tbl.push_back(wr_req(32'h00001000, 32'hFFFFFFFF, 4'hF));
        tbl.push_back(wr_req(32'h30, 32'h00000000, 4'h0));
        tbl.push_back(rd_req(32'h30, 4'hF));
        tbl.push_back(rd_req(32'h00, 4'hF));
        tbl.push_back(rd_req(32'h30, 4'b0110));
        tbl.push_back(rd_req(32'h80000030, 4'hF));
        tbl.push_back(rd_req(32'h30, 4'h0));
        foreach (tbl[i]) begin
            run_one(tbl[i], lat, g);
            seen.push_back(g.rd);
            e = sb.pop_front();
            checks++;
            if (lat != EXP_LAT || g.rv !== e.rv || g.wd !== e.wd || g.er !== e.er || (e.rv && g.rd !== e.rd)) begin
                failures++;
                $display("FAIL illegal[%0d]: got rv=%0b wd=%0b err=%0b rdata=%08h lat=%0d, expected rv=%0b wd=%0b err=%0b rdata=%08h lat=%0d",
                         i, g.rv, g.wd, g.er, g.rd, lat, e.rv, e.wd, e.er, e.rd, EXP_LAT);
            end
        end
        checks++;
        if (seen[5] !== 32'h55667788 || seen[6] !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL illegal_ram_intact: got %08h/%08h expected 55667788/0badf00d", seen[5], seen[6]);
        end
    endtask

    task automatic test_both();
        req_t tbl[$];
        exp_t e, g;
        int   lat;
        tbl.push_back(wr_req(32'h50, 32'h00000000, 4'hF));
        tbl.push_back(rw_req(32'h50, 32'h12345678, 4'hF));
        tbl.push_back(rd_req(32'h50, 4'hF));
        tbl.push_back(rw_req(32'h50, 32'hFFFFFFFF, 4'b0101));
        tbl.push_back(rd_req(32'h50, 4'hF));
        foreach (tbl[i]) begin
            run_one(tbl[i], lat, g);
            e = sb.pop_front();
            checks++;
            if (lat != EXP_LAT || g.rv !== e.rv || g.wd !== e.wd || g.er !== e.er || (e.rv && g.rd !== e.rd)) begin
                failures++;
                $display("FAIL both_rw[%0d]: got rv=%0b wd=%0b err=%0b rdata=%08h lat=%0d, expected rv=%0b wd=%0b err=%0b rdata=%08h lat=%0d",
                         i, g.rv, g.wd, g.er, g.rd, lat, e.rv, e.wd, e.er, e.rd, EXP_LAT);
            end
        end
    endtask

`ifdef DMEM_WAIT_EN
    task automatic test_wait_timing();
        exp_t e;
        logic exp_busy, exp_rv;
        @(posedge clk);
        #1;
        sb.push_back(predict(rd_req(32'h10, 4'hF)));
        drive(rd_req(32'h10, 4'hF));
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            exp_busy = (c < 3);
            exp_rv   = (c == 3);
            checks++;
            if (bus.busy !== exp_busy || bus.rvalid !== exp_rv) begin
                failures++;
                $display("FAIL wait_timing[cycle %0d]: got busy=%0b rv=%0b, expected busy=%0b rv=%0b",
                         c, bus.busy, bus.rvalid, exp_busy, exp_rv);
            end
            if (c == 3) begin
                e = sb.pop_front();
                checks++;
                if (bus.rdata !== e.rd) begin
                    failures++;
                    $display("FAIL wait_rdata: got %08h expected %08h", bus.rdata, e.rd);
                end
            end
            @(posedge clk);
            #1;
            if (c == 0) drive_idle();
        end
    endtask
`else
    task automatic test_back_to_back();
        req_t tbl[$];
        exp_t e;
        tbl.push_back(wr_req(32'h60, 32'hA5A5A5A5, 4'hF));
        tbl.push_back(rd_req(32'h60, 4'hF));
        tbl.push_back(wr_req(32'h62, 32'h00770000, 4'h4));
        tbl.push_back(rd_req(32'h60, 4'hF));
        tbl.push_back(rd_req(32'h10, 4'hF));
        tbl.push_back(wr_req(32'h10, 32'h00000001, 4'h1));
        tbl.push_back(rd_req(32'h10, 4'h3));
        @(posedge clk);
        #1;
        for (int i = 0; i <= tbl.size(); i++) begin
            if (i < tbl.size()) begin
                sb.push_back(predict(tbl[i]));
                drive(tbl[i]);
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.busy !== 1'b0 || bus.rvalid !== e.rv || bus.wdone !== e.wd || bus.err !== e.er ||
                    (e.rv && bus.rdata !== e.rd)) begin
                    failures++;
                    $display("FAIL back_to_back[%0d]: got busy=%0b rv=%0b wd=%0b err=%0b rdata=%08h, expected busy=0 rv=%0b wd=%0b err=%0b rdata=%08h",
                             i - 1, bus.busy, bus.rvalid, bus.wdone, bus.err, bus.rdata, e.rv, e.wd, e.er, e.rd);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    task automatic test_reset_abort();
        exp_t e, g;
        int   lat;
        run_one(wr_req(32'h40, 32'h01020304, 4'hF), lat, g);
        e = sb.pop_front();
        checks++;
        if (lat != EXP_LAT || g.wd !== 1'b1 || g.er !== e.er) begin
            failures++;
            $display("FAIL abort_preload: got wd=%0b err=%0b lat=%0d, expected wd=1 err=%0b lat=%0d",
                     g.wd, g.er, lat, e.er, EXP_LAT);
        end
        drive(wr_req(32'h40, 32'hCAFEF00D, 4'hF));
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.rvalid, bus.wdone, bus.err, bus.rdata} !== 36'h0) begin
                failures++;
                $display("FAIL abort_outputs[%0d]: got busy=%0b rv=%0b wd=%0b err=%0b rdata=%08h, expected all zero",
                         k, bus.busy, bus.rvalid, bus.wdone, bus.err, bus.rdata);
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        run_one(rd_req(32'h40, 4'hF), lat, g);
        e = sb.pop_front();
        checks++;
        if (lat != EXP_LAT || g.rv !== 1'b1 || g.er !== 1'b0 || g.rd !== 32'h01020304 || g.rd !== e.rd) begin
            failures++;
            $display("FAIL abort_readback: got rv=%0b err=%0b rdata=%08h lat=%0d, expected rv=1 err=0 rdata=01020304 lat=%0d",
                     g.rv, g.er, g.rd, lat, EXP_LAT);
        end
    endtask

    initial begin
        bus.memAddr = 32'h0;
        bus.memData = 32'h0;
        bus.rmask   = 4'h0;
        bus.wmask   = 4'h0;
        drive_idle();
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_illegal();
        test_both();
`ifdef DMEM_WAIT_EN
        test_wait_timing();
`else
        test_back_to_back();
`endif
        test_reset_abort();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
